// File: rtl/special_reg_bank.sv
// Special-register bank: PC, LR, MR, FLAGS, EPC and read-only STATUS, with hardware
// PC sequencing (step/branch/call/return/trap/eret), masked flag updates and two read ports.
module special_reg_bank #(
    parameter int                DATA_W   = 64,
    parameter int                FLAG_W   = 4,
    parameter int                PC_STEP  = 4,
    parameter logic [DATA_W-1:0] PC_RESET = '0,
    parameter logic [DATA_W-1:0] TRAP_VEC = DATA_W'('h100)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [2:0]        wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [2:0]        rd_addr_a_i,
    output logic [DATA_W-1:0] rd_data_a_o,
    input  logic [2:0]        rd_addr_b_i,
    output logic [DATA_W-1:0] rd_data_b_o,
    input  logic              pc_stall_i,
    input  logic              br_en_i,
    input  logic              call_en_i,
    input  logic [DATA_W-1:0] br_target_i,
    input  logic              ret_en_i,
    input  logic              trap_en_i,
    input  logic              eret_en_i,
    input  logic              flag_we_i,
    input  logic [FLAG_W-1:0] flag_mask_i,
    input  logic [FLAG_W-1:0] flag_in_i,
    output logic [DATA_W-1:0] pc_o,
    output logic              in_trap_o
);

    localparam logic [2:0] A_PC     = 3'd0;
    localparam logic [2:0] A_LR     = 3'd1;
    localparam logic [2:0] A_MR     = 3'd2;
    localparam logic [2:0] A_FLAGS  = 3'd3;
    localparam logic [2:0] A_EPC    = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;

    typedef enum logic [2:0] {
        PC_SRC_TRAP,
        PC_SRC_ERET,
        PC_SRC_WR,
        PC_SRC_BR,
        PC_SRC_RET,
        PC_SRC_HOLD,
        PC_SRC_STEP
    } pc_src_e;

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] lr_q, lr_d;
    logic [DATA_W-1:0] mr_q, mr_d;
    logic [DATA_W-1:0] epc_q, epc_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              in_trap_q, in_trap_d;

    logic [DATA_W-1:0] pc_inc;
    logic              eret_take;
    pc_src_e           pc_src;

    assign pc_inc    = pc_q + DATA_W'(PC_STEP);
    // eret outside a trap is ignored so the lower-priority sources still apply
    assign eret_take = eret_en_i & in_trap_q;

    always_comb begin
        pc_src = PC_SRC_STEP;
        if (trap_en_i)                           pc_src = PC_SRC_TRAP;
        else if (eret_take)                      pc_src = PC_SRC_ERET;
        else if (wr_en_i && wr_addr_i == A_PC)   pc_src = PC_SRC_WR;
        else if (call_en_i || br_en_i)           pc_src = PC_SRC_BR;
        else if (ret_en_i)                       pc_src = PC_SRC_RET;
        else if (pc_stall_i)                     pc_src = PC_SRC_HOLD;
    end

    always_comb begin
        pc_d = pc_inc;
        case (pc_src)
            PC_SRC_TRAP: pc_d = TRAP_VEC;
            PC_SRC_ERET: pc_d = epc_q;
            PC_SRC_WR:   pc_d = wr_data_i;
            PC_SRC_BR:   pc_d = br_target_i;
            PC_SRC_RET:  pc_d = lr_q;
            PC_SRC_HOLD: pc_d = pc_q;
            default:     pc_d = pc_inc;
        endcase
    end

    // Link only when the call actually steered the PC
    always_comb begin
        lr_d = lr_q;
        if (pc_src == PC_SRC_BR && call_en_i)     lr_d = pc_inc;
        else if (wr_en_i && wr_addr_i == A_LR)    lr_d = wr_data_i;
    end

    always_comb begin
        mr_d = mr_q;
        if (wr_en_i && wr_addr_i == A_MR) mr_d = wr_data_i;
    end

    always_comb begin
        flags_d = flags_q;
        if (wr_en_i && wr_addr_i == A_FLAGS) flags_d = wr_data_i[FLAG_W-1:0];
        else if (flag_we_i)                  flags_d = (flags_q & ~flag_mask_i) | (flag_in_i & flag_mask_i);
    end

    // Nested traps keep the EPC of the outermost trap
    always_comb begin
        epc_d = epc_q;
        if (trap_en_i && !in_trap_q)            epc_d = pc_q;
        else if (wr_en_i && wr_addr_i == A_EPC) epc_d = wr_data_i;
    end

    always_comb begin
        in_trap_d = in_trap_q;
        if (trap_en_i)      in_trap_d = 1'b1;
        else if (eret_take) in_trap_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q      <= PC_RESET;
            lr_q      <= '0;
            mr_q      <= '0;
            epc_q     <= '0;
            flags_q   <= '0;
            in_trap_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            lr_q      <= lr_d;
            mr_q      <= mr_d;
            epc_q     <= epc_d;
            flags_q   <= flags_d;
            in_trap_q <= in_trap_d;
        end
    end

    logic [1:0][2:0]        rd_addr;
    logic [1:0][DATA_W-1:0] rd_data;

    assign rd_addr = {rd_addr_b_i, rd_addr_a_i};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            rd_data[p] = '0;
            case (rd_addr[p])
                A_PC:     rd_data[p] = pc_q;
                A_LR:     rd_data[p] = lr_q;
                A_MR:     rd_data[p] = mr_q;
                A_FLAGS:  rd_data[p] = {{(DATA_W-FLAG_W){1'b0}}, flags_q};
                A_EPC:    rd_data[p] = epc_q;
                A_STATUS: rd_data[p] = {{(DATA_W-1){1'b0}}, in_trap_q};
                default:  rd_data[p] = '0;
            endcase
        end
    end

    assign rd_data_a_o = rd_data[0];
    assign rd_data_b_o = rd_data[1];
    assign pc_o        = pc_q;
    assign in_trap_o   = in_trap_q;

endmodule

// File: tb/tb_special_reg_bank.sv
// Directed bench for special_reg_bank: reset, sequencing, traps, flags, wrap, read ports.
module tb_special_reg_bank;

    localparam int DATA_W = 64;
    localparam int FLAG_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [2:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [2:0]        rd_addr_a, rd_addr_b;
    logic [DATA_W-1:0] rd_data_a, rd_data_b;
    logic              pc_stall, br_en, call_en, ret_en, trap_en, eret_en, flag_we;
    logic [DATA_W-1:0] br_target;
    logic [FLAG_W-1:0] flag_mask, flag_in;
    logic [DATA_W-1:0] pc;
    logic              in_trap;

    int checks = 0;
    int errors = 0;

    special_reg_bank dut (
        .clk_i(clk), .rst_i(rst),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_addr_a_i(rd_addr_a), .rd_data_a_o(rd_data_a),
        .rd_addr_b_i(rd_addr_b), .rd_data_b_o(rd_data_b),
        .pc_stall_i(pc_stall), .br_en_i(br_en), .call_en_i(call_en),
        .br_target_i(br_target), .ret_en_i(ret_en), .trap_en_i(trap_en),
        .eret_en_i(eret_en), .flag_we_i(flag_we), .flag_mask_i(flag_mask),
        .flag_in_i(flag_in), .pc_o(pc), .in_trap_o(in_trap)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_en = 0; wr_addr = 0; wr_data = 0; pc_stall = 0; br_en = 0; call_en = 0;
        br_target = 0; ret_en = 0; trap_en = 0; eret_en = 0; flag_we = 0;
        flag_mask = 0; flag_in = 0;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [DATA_W-1:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 0;
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs(); rd_addr_a = 0; rd_addr_b = 0;
        tick(); tick();
        rst = 0;
        checks++; if (pc !== 64'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 64'h0); end
        checks++; if (in_trap !== 1'b0) begin errors++; $display("FAIL reset_in_trap got %b exp 0", in_trap); end
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
            #1;
            checks++; if (rd_data_a !== '0) begin errors++; $display("FAIL reset_rd_a[%0d] got %h exp 0", i, rd_data_a); end
            checks++; if (rd_data_b !== '0) begin errors++; $display("FAIL reset_rd_b[%0d] got %h exp 0", 7 - i, rd_data_b); end
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (pc !== 64'(4 * i)) begin errors++; $display("FAIL idle_step%0d got %h exp %h", i, pc, 64'(4 * i)); end
        end
    endtask

    task automatic test_call_ret();
        write_reg(3'd0, 64'h20);
        call_en = 1; br_target = 64'h80;
        tick();
        call_en = 0;
        rd_addr_a = 3'd1; #1;
        checks++; if (pc !== 64'h80) begin errors++; $display("FAIL call_pc got %h exp %h", pc, 64'h80); end
        checks++; if (rd_data_a !== 64'h24) begin errors++; $display("FAIL call_lr got %h exp %h", rd_data_a, 64'h24); end
        pc_stall = 1; tick(); pc_stall = 0;
        checks++; if (pc !== 64'h80) begin errors++; $display("FAIL stall_pc got %h exp %h", pc, 64'h80); end
        ret_en = 1; tick(); ret_en = 0;
        checks++; if (pc !== 64'h24) begin errors++; $display("FAIL ret_pc got %h exp %h", pc, 64'h24); end
    endtask

    task automatic test_trap();
        write_reg(3'd0, 64'h40);
        trap_en = 1; tick(); trap_en = 0;
        rd_addr_a = 3'd4; rd_addr_b = 3'd5; #1;
        checks++; if (pc !== 64'h100) begin errors++; $display("FAIL trap_pc got %h exp %h", pc, 64'h100); end
        checks++; if (rd_data_a !== 64'h40) begin errors++; $display("FAIL trap_epc got %h exp %h", rd_data_a, 64'h40); end
        checks++; if (in_trap !== 1'b1) begin errors++; $display("FAIL trap_in_trap got %b exp 1", in_trap); end
        checks++; if (rd_data_b !== 64'h1) begin errors++; $display("FAIL trap_status got %h exp 1", rd_data_b); end
        tick();
        checks++; if (pc !== 64'h104) begin errors++; $display("FAIL trap_step got %h exp %h", pc, 64'h104); end
        trap_en = 1; tick(); trap_en = 0;
        checks++; if (pc !== 64'h100) begin errors++; $display("FAIL nested_pc got %h exp %h", pc, 64'h100); end
        checks++; if (rd_data_a !== 64'h40) begin errors++; $display("FAIL nested_epc got %h exp %h", rd_data_a, 64'h40); end
        eret_en = 1; tick(); eret_en = 0;
        checks++; if (pc !== 64'h40) begin errors++; $display("FAIL eret_pc got %h exp %h", pc, 64'h40); end
        checks++; if (in_trap !== 1'b0) begin errors++; $display("FAIL eret_in_trap got %b exp 0", in_trap); end
    endtask

    task automatic test_call_priority();
        rd_addr_a = 3'd1;
        write_reg(3'd1, 64'h111);
        // PC write beats call: no link
        call_en = 1; br_target = 64'h80; wr_en = 1; wr_addr = 3'd0; wr_data = 64'h300;
        tick(); call_en = 0; wr_en = 0;
        checks++; if (pc !== 64'h300) begin errors++; $display("FAIL callwr_pc got %h exp %h", pc, 64'h300); end
        checks++; if (rd_data_a !== 64'h111) begin errors++; $display("FAIL callwr_lr got %h exp %h", rd_data_a, 64'h111); end
        call_en = 1; trap_en = 1;
        tick(); call_en = 0; trap_en = 0;
        rd_addr_b = 3'd4; #1;
        checks++; if (pc !== 64'h100) begin errors++; $display("FAIL calltrap_pc got %h exp %h", pc, 64'h100); end
        checks++; if (rd_data_a !== 64'h111) begin errors++; $display("FAIL calltrap_lr got %h exp %h", rd_data_a, 64'h111); end
        checks++; if (rd_data_b !== 64'h300) begin errors++; $display("FAIL calltrap_epc got %h exp %h", rd_data_b, 64'h300); end
        eret_en = 1; tick(); eret_en = 0;
        checks++; if (pc !== 64'h300) begin errors++; $display("FAIL eret2_pc got %h exp %h", pc, 64'h300); end
        call_en = 1; wr_en = 1; wr_addr = 3'd1; wr_data = 64'h999;
        tick(); call_en = 0; wr_en = 0;
        checks++; if (pc !== 64'h80) begin errors++; $display("FAIL calllr_pc got %h exp %h", pc, 64'h80); end
        checks++; if (rd_data_a !== 64'h304) begin errors++; $display("FAIL calllr_lr got %h exp %h", rd_data_a, 64'h304); end
    endtask

    task automatic test_flags();
        rd_addr_a = 3'd3;
        write_reg(3'd3, 64'hA);
        flag_we = 1; flag_mask = 4'b0011; flag_in = 4'b0101;
        tick();
        checks++; if (rd_data_a !== 64'h9) begin errors++; $display("FAIL flag_mask got %h exp %h", rd_data_a, 64'h9); end
        wr_en = 1; wr_addr = 3'd3; wr_data = 64'hF;
        tick(); wr_en = 0; flag_we = 0;
        checks++; if (rd_data_a !== 64'hF) begin errors++; $display("FAIL flag_wr_over got %h exp %h", rd_data_a, 64'hF); end
        write_reg(3'd3, 64'hFFFF_FFFF_FFFF_FFF6);
        checks++; if (rd_data_a !== 64'h6) begin errors++; $display("FAIL flag_zext got %h exp %h", rd_data_a, 64'h6); end
    endtask

    task automatic test_wrap();
        write_reg(3'd0, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        checks++; if (pc !== 64'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", pc); end
        wr_en = 1; wr_addr = 3'd0; wr_data = 64'h500; br_en = 1; br_target = 64'h80;
        tick(); wr_en = 0; br_en = 0;
        checks++; if (pc !== 64'h500) begin errors++; $display("FAIL wr_over_br got %h exp %h", pc, 64'h500); end
    endtask

    task automatic test_read_ports();
        rd_addr_a = 3'd2; rd_addr_b = 3'd6;
        wr_en = 1; wr_addr = 3'd2; wr_data = 64'hDEAD;
        #1;
        checks++; if (rd_data_a !== 64'h0) begin errors++; $display("FAIL mr_no_bypass got %h exp 0", rd_data_a); end
        tick(); wr_en = 0;
        checks++; if (rd_data_a !== 64'hDEAD) begin errors++; $display("FAIL mr_write got %h exp %h", rd_data_a, 64'hDEAD); end
        write_reg(3'd6, 64'h55);
        checks++; if (rd_data_b !== 64'h0) begin errors++; $display("FAIL reserved_rd got %h exp 0", rd_data_b); end
        rd_addr_b = 3'd5;
        write_reg(3'd5, 64'h1);
        checks++; if (rd_data_b !== 64'h0) begin errors++; $display("FAIL status_ro got %h exp 0", rd_data_b); end
        write_reg(3'd0, 64'h700);
        eret_en = 1; tick(); eret_en = 0;
        rd_addr_b = 3'd0; #1;
        checks++; if (pc !== 64'h704) begin errors++; $display("FAIL eret_noop got %h exp %h", pc, 64'h704); end
        checks++; if (rd_data_b !== 64'h704) begin errors++; $display("FAIL rd_b_pc got %h exp %h", rd_data_b, 64'h704); end
    endtask

    task automatic test_reset_override();
        trap_en = 1; wr_en = 1; wr_addr = 3'd2; wr_data = 64'h1234; rst = 1;
        tick();
        clear_inputs(); rst = 0;
        rd_addr_a = 3'd2; #1;
        checks++; if (pc !== 64'h0) begin errors++; $display("FAIL rst_over_pc got %h exp 0", pc); end
        checks++; if (in_trap !== 1'b0) begin errors++; $display("FAIL rst_over_trap got %b exp 0", in_trap); end
        checks++; if (rd_data_a !== 64'h0) begin errors++; $display("FAIL rst_over_mr got %h exp 0", rd_data_a); end
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_trap();
        test_call_priority();
        test_flags();
        test_wrap();
        test_read_ports();
        test_reset_override();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
